// File: rtl/mux_response_checker_pkg.sv
// Common types for the mux response checker; state values come from mux_checker_defs.vh.
package mux_response_checker_pkg;

`include "mux_checker_defs.vh"

    typedef enum logic [1:0] {
        ST_IDLE = `MUX_CHK_ST_IDLE,
        ST_RUN  = `MUX_CHK_ST_RUN,
        ST_DONE = `MUX_CHK_ST_DONE
    } state_t;

endpackage

// File: rtl/mux_checker_defs.vh
// Shared FSM state encodings for the mux response checker.
`ifndef MUX_CHECKER_DEFS_VH
`define MUX_CHECKER_DEFS_VH

`define MUX_CHK_ST_IDLE 2'd0
`define MUX_CHK_ST_RUN  2'd1
`define MUX_CHK_ST_DONE 2'd2

`endif

// File: rtl/mux_ref_model.sv
// Combinational golden 2:1 mux: the value the checked mux should produce.
module mux_ref_model #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sel,
    output logic [WIDTH-1:0] o_expected
);

    assign o_expected = i_sel ? i_b : i_a;

endmodule

// File: rtl/mux_response_checker.sv
// Checks observed 2:1 mux vectors against a reference, counting passes/fails per run.
// Define MUX_CHECKER_CAPTURE_EN to add cap_* outputs holding the first mismatch of a run.
module mux_response_checker
    import mux_response_checker_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_z,
    input  logic             in_last,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] vec_idx,
    output logic             err
`ifdef MUX_CHECKER_CAPTURE_EN
    ,
    output logic             cap_valid,
    output logic [CNT_W-1:0] cap_idx,
    output logic [WIDTH-1:0] cap_a,
    output logic [WIDTH-1:0] cap_b,
    output logic [WIDTH-1:0] cap_z,
    output logic             cap_sel
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_pass_cnt;
    logic [CNT_W-1:0]   r_fail_cnt;
    logic [CNT_W-1:0]   r_vec_idx;
    logic               r_err;
    logic [WIDTH-1:0]   w_expected;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_match;
    logic               w_start_run;

    mux_ref_model #(
        .WIDTH(WIDTH)
    ) u_ref (
        .i_a        (in_a),
        .i_b        (in_b),
        .i_sel      (in_sel),
        .o_expected (w_expected)
    );

    assign w_in_ready  = (r_state == ST_RUN);
    assign w_accept    = in_valid && w_in_ready;
    assign w_match     = (in_z == w_expected);
    assign w_start_run = start && (r_state != ST_RUN);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: next state gets its default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_next_state = ST_RUN;
            ST_RUN:           if (w_accept && in_last) w_next_state = ST_DONE;
            default:          w_next_state = ST_IDLE;
        endcase
    end

    // Counters saturate at all-ones; start only clears when not already running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_vec_idx  <= '0;
            r_err      <= 1'b0;
        end else if (w_start_run) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_vec_idx  <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            if (w_match) begin
                if (r_pass_cnt != CNT_MAX) r_pass_cnt <= r_pass_cnt + CNT_ONE;
            end else begin
                if (r_fail_cnt != CNT_MAX) r_fail_cnt <= r_fail_cnt + CNT_ONE;
                r_err <= 1'b1;
            end
            if (r_vec_idx != CNT_MAX) r_vec_idx <= r_vec_idx + CNT_ONE;
        end
    end

`ifdef MUX_CHECKER_CAPTURE_EN
    logic             r_cap_valid;
    logic [CNT_W-1:0] r_cap_idx;
    logic [WIDTH-1:0] r_cap_a;
    logic [WIDTH-1:0] r_cap_b;
    logic [WIDTH-1:0] r_cap_z;
    logic             r_cap_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cap_valid <= 1'b0;
            r_cap_idx   <= '0;
            r_cap_a     <= '0;
            r_cap_b     <= '0;
            r_cap_z     <= '0;
            r_cap_sel   <= 1'b0;
        end else if (w_start_run) begin
            r_cap_valid <= 1'b0;
            r_cap_idx   <= '0;
            r_cap_a     <= '0;
            r_cap_b     <= '0;
            r_cap_z     <= '0;
            r_cap_sel   <= 1'b0;
        end else if (w_accept && !w_match && !r_cap_valid) begin
            r_cap_valid <= 1'b1;
            r_cap_idx   <= r_vec_idx;
            r_cap_a     <= in_a;
            r_cap_b     <= in_b;
            r_cap_z     <= in_z;
            r_cap_sel   <= in_sel;
        end
    end

    assign cap_valid = r_cap_valid;
    assign cap_idx   = r_cap_idx;
    assign cap_a     = r_cap_a;
    assign cap_b     = r_cap_b;
    assign cap_z     = r_cap_z;
    assign cap_sel   = r_cap_sel;
`endif

    assign in_ready = w_in_ready;
    assign busy     = w_in_ready;
    assign done     = (r_state == ST_DONE);
    assign pass_cnt = r_pass_cnt;
    assign fail_cnt = r_fail_cnt;
    assign vec_idx  = r_vec_idx;
    assign err      = r_err;

endmodule

// File: tb/tb_mux_response_checker.sv
// Scoreboard bench for mux_response_checker: a run-level model predicts counters per accepted vector.
module tb_mux_response_checker;

    localparam int W      = 64;
    localparam int MAX16  = 65535;
    localparam int MAX4   = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          start4 = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_sel = 1'b0;
    logic [W-1:0]  in_z = '0;
    logic          in_last = 1'b0;

    logic          in_ready, busy, done, err;
    logic [15:0]   pass_cnt, fail_cnt, vec_idx;
    logic          in_ready4, busy4, done4, err4;
    logic [3:0]    pass4, fail4, idx4;
`ifdef MUX_CHECKER_CAPTURE_EN
    logic          cap_valid, cap_sel, cap_valid4, cap_sel4;
    logic [15:0]   cap_idx;
    logic [3:0]    cap_idx4;
    logic [W-1:0]  cap_a, cap_b, cap_z, cap_a4, cap_b4, cap_z4;
`endif

    always #5 clk = ~clk;

    mux_response_checker #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_z(in_z), .in_last(in_last),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .vec_idx(vec_idx), .err(err)
`ifdef MUX_CHECKER_CAPTURE_EN
        , .cap_valid(cap_valid), .cap_idx(cap_idx), .cap_a(cap_a), .cap_b(cap_b),
        .cap_z(cap_z), .cap_sel(cap_sel)
`endif
    );

    mux_response_checker #(.WIDTH(W), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .in_valid(in_valid), .in_ready(in_ready4),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_z(in_z), .in_last(in_last),
        .busy(busy4), .done(done4), .pass_cnt(pass4), .fail_cnt(fail4),
        .vec_idx(idx4), .err(err4)
`ifdef MUX_CHECKER_CAPTURE_EN
        , .cap_valid(cap_valid4), .cap_idx(cap_idx4), .cap_a(cap_a4), .cap_b(cap_b4),
        .cap_z(cap_z4), .cap_sel(cap_sel4)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Run-level reference model of the main checker.
    typedef struct {
        int           pass;
        int           fail;
        int           idx;
        bit           err;
        bit           run;
        bit           done;
        bit           cap_valid;
        int           cap_idx;
        logic [W-1:0] cap_a;
        logic [W-1:0] cap_b;
        logic [W-1:0] cap_z;
        bit           cap_sel;
    } model_t;

    model_t m;
    model_t sb_q[$];

    function automatic int sat_inc(input int v, input int max);
        return (v >= max) ? max : v + 1;
    endfunction

    function automatic model_t model_clear();
        model_t r;
        r.pass = 0; r.fail = 0; r.idx = 0; r.err = 0; r.run = 0; r.done = 0;
        r.cap_valid = 0; r.cap_idx = 0; r.cap_a = '0; r.cap_b = '0; r.cap_z = '0; r.cap_sel = 0;
        return r;
    endfunction

    task automatic send_vec(input logic [W-1:0] a, input logic [W-1:0] b, input bit sel,
                            input logic [W-1:0] z, input bit last);
        logic [W-1:0] want;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_sel = sel; in_z = z; in_last = last;
        if (m.run) begin
            want = sel ? b : a;
            if (z == want) begin
                m.pass = sat_inc(m.pass, MAX16);
            end else begin
                m.fail = sat_inc(m.fail, MAX16);
                m.err  = 1;
                if (!m.cap_valid) begin
                    m.cap_valid = 1; m.cap_idx = m.idx;
                    m.cap_a = a; m.cap_b = b; m.cap_z = z; m.cap_sel = sel;
                end
            end
            m.idx = sat_inc(m.idx, MAX16);
            if (last) begin m.run = 0; m.done = 1; end
            sb_q.push_back(m);
        end
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        if (!m.run) begin
            m = model_clear();
            m.run = 1;
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2 reset = 1'b1;
        m = model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, "_busy"},     busy,     m.run);
        check({tag, "_in_ready"}, in_ready, m.run);
        check({tag, "_done"},     done,     m.done);
        check({tag, "_pass"},     pass_cnt, m.pass);
        check({tag, "_fail"},     fail_cnt, m.fail);
        check({tag, "_idx"},      vec_idx,  m.idx);
        check({tag, "_err"},      err,      m.err);
`ifdef MUX_CHECKER_CAPTURE_EN
        check({tag, "_cap_valid"}, cap_valid, m.cap_valid);
        check({tag, "_cap_idx"},   cap_idx,   m.cap_idx);
        check({tag, "_cap_z"},     cap_z,     m.cap_z);
`endif
    endtask

    // Monitor: whenever the main DUT accepts a vector, compare its outputs one cycle later.
    initial begin : monitor
        model_t e;
        bit     acc;
        forever begin
            @(posedge clk);
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) begin
                check("sb_expected_accept", (sb_q.size() != 0), 1'b1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("sb_pass", pass_cnt, e.pass);
                    check("sb_fail", fail_cnt, e.fail);
                    check("sb_idx",  vec_idx,  e.idx);
                    check("sb_err",  err,      e.err);
                    check("sb_done", done,     e.done);
                    check("sb_busy", busy,     e.run);
`ifdef MUX_CHECKER_CAPTURE_EN
                    check("sb_cap_valid", cap_valid, e.cap_valid);
                    check("sb_cap_idx",   cap_idx,   e.cap_idx);
                    check("sb_cap_a",     cap_a,     e.cap_a);
                    check("sb_cap_b",     cap_b,     e.cap_b);
                    check("sb_cap_z",     cap_z,     e.cap_z);
                    check("sb_cap_sel",   cap_sel,   e.cap_sel);
`endif
                end
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [W-1:0] ra, rb, rz;
        bit           rs;
        int           exp4_pass, exp4_idx;

        m = model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_state("reset");

        // Vectors in IDLE are ignored.
        send_vec(64'd7, 64'd8, 1'b0, 64'd3, 1'b0);
        send_vec(64'd7, 64'd8, 1'b1, 64'd8, 1'b1);
        check_state("idle_ignore");

        // Basic three-vector run.
        start_pulse();
        send_vec(64'd5, 64'd9, 1'b0, 64'd5, 1'b0);
        send_vec(64'd5, 64'd9, 1'b1, 64'd9, 1'b0);
        send_vec(64'd0, 64'd0, 1'b1, 64'd0, 1'b1);
        check_state("basic");
        check("basic_pass_3", pass_cnt, 64'd3);
        check("basic_done",   done,     1'b1);

        // Vectors in DONE are ignored, including mismatches and last.
        send_vec(64'd1, 64'd2, 1'b0, 64'd9, 1'b0);
        send_vec(64'd1, 64'd2, 1'b1, 64'd9, 1'b1);
        check_state("done_ignore");

        // Start during RUN is ignored: counters keep going, no restart.
        start_pulse();
        send_vec(64'd4, 64'd6, 1'b0, 64'd4, 1'b0);
        start_pulse();
        check_state("start_in_run");
        send_vec(64'd4, 64'd6, 1'b1, 64'd7, 1'b0);
        start_pulse();
        send_vec(64'd4, 64'd6, 1'b1, 64'd6, 1'b1);
        check_state("start_in_run_end");
        check("start_in_run_idx", vec_idx, 64'd3);

        // Single mismatch: selected b=2 but observed 1.
        start_pulse();
        send_vec(64'd1, 64'd2, 1'b1, 64'd1, 1'b1);
        check_state("mismatch");
        check("mismatch_fail_1", fail_cnt, 64'd1);
        check("mismatch_err",    err,      1'b1);
`ifdef MUX_CHECKER_CAPTURE_EN
        check("mismatch_cap_idx_0", cap_idx,   64'd0);
        check("mismatch_cap_z_1",   cap_z,     64'd1);
        check("mismatch_cap_valid", cap_valid, 1'b1);
`endif

        // Full 31x31x2 sweep with correct responses.
        start_pulse();
        for (int a = 0; a < 31; a++)
            for (int b = 0; b < 31; b++)
                for (int s = 0; s < 2; s++)
                    send_vec(W'(a), W'(b), s[0], (s == 1) ? W'(b) : W'(a),
                             (a == 30) && (b == 30) && (s == 1));
        check_state("sweep");
        check("sweep_pass_1922", pass_cnt, 64'd1922);
        check("sweep_fail_0",    fail_cnt, 64'd0);

        // Randomized run with gaps and roughly one mismatch in four.
        start_pulse();
        for (int i = 0; i < 300; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs = $urandom_range(1, 0);
            rz = rs ? rb : ra;
            if ($urandom_range(3, 0) == 0) rz = rz ^ (W'(1) << $urandom_range(W - 1, 0));
            send_vec(ra, rb, rs, rz, i == 299);
            if ($urandom_range(2, 0) == 0) @(negedge clk);
        end
        check_state("random");

        // Reset in the middle of a run discards everything.
        start_pulse();
        for (int i = 0; i < 4; i++) send_vec(W'(i), W'(i + 10), 1'b0, W'(i), 1'b0);
        check_state("pre_reset");
        reset_pulse();
        check_state("mid_reset");
        check("mid_reset_busy", busy,     1'b0);
        check("mid_reset_idx",  vec_idx,  64'd0);
        start_pulse();
        send_vec(64'd3, 64'd4, 1'b0, 64'd3, 1'b0);
        send_vec(64'd3, 64'd4, 1'b1, 64'd4, 1'b1);
        check_state("after_reset");
        check("after_reset_pass_2", pass_cnt, 64'd2);

        // Narrow counters saturate: 20 passing vectors into a CNT_W=4 instance.
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        exp4_pass = 0;
        exp4_idx  = 0;
        for (int i = 0; i < 20; i++) begin
            send_vec(W'(i * 3), W'(i * 5), i[0], i[0] ? W'(i * 5) : W'(i * 3), i == 19);
            exp4_pass = sat_inc(exp4_pass, MAX4);
            exp4_idx  = sat_inc(exp4_idx, MAX4);
        end
        @(negedge clk);
        check("sat_pass4", pass4, exp4_pass);
        check("sat_idx4",  idx4,  exp4_idx);
        check("sat_fail4", fail4, 64'd0);
        check("sat_done4", done4, 1'b1);
        check("sat_busy4", busy4, 1'b0);
        check("sat_err4",  err4,  1'b0);
        check_state("main_during_dut4");

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
